// File: rtl/oldland_cpuid_reader.sv
// oldland_cpuid_reader: walks the CPUID selector over every implemented
// register, snapshots the values, then streams them out over valid/ready.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               request a scan+stream; only honoured in IDLE
//   busy                high in every state except IDLE
//   cpuid_sel/val       selector to the CPUID bank and its combinational data
//   out_data/index/last stream payload, qualified by out_valid
//   out_valid/ready     stream handshake
//   done                one-cycle pulse after the last word is accepted
//
// Build option: define CPUID_CHECKSUM_EN to append an XOR checksum word
// (index NUM_REGS) after the register words.
module oldland_cpuid_reader #(
    parameter int NUM_REGS  = 6,
    parameter int SEL_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic [SEL_WIDTH-1:0] cpuid_sel,
    input  logic [31:0]          cpuid_val,
    output logic [31:0]          out_data,
    output logic [SEL_WIDTH-1:0] out_index,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 done
);

    localparam int CW = SEL_WIDTH + 1;
`ifdef CPUID_CHECKSUM_EN
    localparam int NUM_WORDS = NUM_REGS + 1;
`else
    localparam int NUM_WORDS = NUM_REGS;
`endif
    localparam logic [CW-1:0] LAST_REG  = CW'(NUM_REGS - 1);
    localparam logic [CW-1:0] LAST_WORD = CW'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        STREAM,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   idx_q, idx_d;
    logic [31:0]     data_q, data_d;
    logic [SEL_WIDTH-1:0] index_q, index_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic            done_q, done_d;

    logic [31:0]     buf_q [NUM_REGS];
    logic [CW-1:0]   nidx;
    logic [31:0]     nxt_word;
    logic [31:0]     first_word;

`ifdef CPUID_CHECKSUM_EN
    logic [31:0]     csum_q, csum_d;
`endif

    assign nidx = idx_q + CW'(1);

    // Next word to present after a handshake.
    always_comb begin
        nxt_word = buf_q[nidx[SEL_WIDTH-1:0]];
`ifdef CPUID_CHECKSUM_EN
        if (nidx == CW'(NUM_REGS))
            nxt_word = csum_q;
`endif
    end

    // Word 0 is loaded on the last scan edge; when NUM_REGS==1 it is
    // being captured on that very edge, so take it straight from the bank.
    assign first_word = (cnt_q == '0) ? cpuid_val : buf_q[0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        index_d = index_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
`ifdef CPUID_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    cnt_d   = '0;
`ifdef CPUID_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            SCAN: begin
`ifdef CPUID_CHECKSUM_EN
                csum_d = csum_q ^ cpuid_val;
`endif
                if (cnt_q == LAST_REG) begin
                    state_d = STREAM;
                    cnt_d   = '0;
                    idx_d   = '0;
                    valid_d = 1'b1;
                    data_d  = first_word;
                    index_d = '0;
                    last_d  = (LAST_WORD == '0);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (last_q) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        data_d  = '0;
                        index_d = '0;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = nidx;
                        data_d  = nxt_word;
                        index_d = nidx[SEL_WIDTH-1:0];
                        last_d  = (nidx == LAST_WORD);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            index_q <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef CPUID_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            index_q <= index_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
`ifdef CPUID_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // Snapshot storage needs no reset; it is always rewritten before use.
    always_ff @(posedge clk) begin
        if (state_q == SCAN)
            buf_q[cnt_q[SEL_WIDTH-1:0]] <= cpuid_val;
    end

    assign busy      = (state_q != IDLE);
    assign cpuid_sel = cnt_q[SEL_WIDTH-1:0];
    assign out_data  = data_q;
    assign out_index = index_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign done      = done_q;

endmodule

// File: tb/tb_oldland_cpuid_reader.sv
// Bench for oldland_cpuid_reader: table of run scenarios plus
// hand-written scan, back-pressure and reset-abort sequences.
module tb_oldland_cpuid_reader;

    localparam int N  = 6;
    localparam int SW = 3;
`ifdef CPUID_CHECKSUM_EN
    localparam int WORDS = N + 1;
`else
    localparam int WORDS = N;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic [SW-1:0] cpuid_sel;
    logic [31:0]   cpuid_val;
    logic [31:0]   out_data;
    logic [SW-1:0] out_index;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          done;

    logic [31:0]   bank [8];

    always #5 clk = ~clk;

    assign cpuid_val = bank[cpuid_sel];

    oldland_cpuid_reader #(.NUM_REGS(N), .SEL_WIDTH(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .cpuid_sel (cpuid_sel),
        .cpuid_val (cpuid_val),
        .out_data  (out_data),
        .out_index (out_index),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .done      (done)
    );

    typedef struct {
        logic [31:0]   data;
        logic [SW-1:0] index;
        logic          last;
    } exp_t;

    typedef struct {
        bit alt;
        int stall_idx;
        int stall_n;
        bit clobber;
        bit spam;
        int abort_at;
    } vec_t;

    localparam logic [31:0] PLAN [N] = '{
        32'h00010002, 32'h02FAF080, 32'h00000000,
        32'h02008008, 32'h04010008, 32'h00080008
    };
    localparam logic [31:0] ALT [N] = '{
        32'hDEADBEEF, 32'h12345678, 32'hA5A5A5A5,
        32'h00000000, 32'hFFFFFFFF, 32'h80000001
    };

    int   vecs = 0;
    int   miss = 0;
    int   nsent;
    int   dcount;
    exp_t q[$];

    bit            prev_stall = 1'b0;
    logic [31:0]   sv_data;
    logic [SW-1:0] sv_index;
    logic          sv_last;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (done)
                dcount++;
            if (prev_stall) begin
                chk("hold_data", out_data, sv_data);
                chk("hold_index", 32'(out_index), 32'(sv_index));
                chk("hold_last", 32'(out_last), 32'(sv_last));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("extra_word", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("word_data", out_data, e.data);
                    chk("word_index", 32'(out_index), 32'(e.index));
                    chk("word_last", 32'(out_last), 32'(e.last));
                    nsent++;
                end
            end
            prev_stall = out_valid && !out_ready;
            sv_data  = out_data;
            sv_index = out_index;
            sv_last  = out_last;
        end
    end

    task automatic run(input vec_t t);
        logic [31:0] cs;
        int          stall_left;
        bit          tmo;
        cs = '0;
        for (int k = 0; k < N; k++)
            bank[k] = t.alt ? ALT[k] : PLAN[k];
        q.delete();
        nsent  = 0;
        dcount = 0;
        for (int k = 0; k < N; k++) begin
            exp_t e;
            e.data  = bank[k];
            e.index = SW'(k);
            e.last  = (k == WORDS - 1);
            cs      = cs ^ bank[k];
            q.push_back(e);
        end
`ifdef CPUID_CHECKSUM_EN
        begin
            exp_t e;
            e.data  = cs;
            e.index = SW'(N);
            e.last  = 1'b1;
            q.push_back(e);
        end
`endif
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = t.spam;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            chk("scan_sel", 32'(cpuid_sel), 32'(k));
            chk("scan_busy", 32'(busy), 32'd1);
            chk("scan_valid", 32'(out_valid), 32'd0);
            @(posedge clk); #1;
        end
        chk("first_valid", 32'(out_valid), 32'd1);
        if (t.clobber)
            for (int k = 0; k < 8; k++)
                bank[k] = 32'hFFFFFFFF;
        stall_left = t.stall_n;
        tmo = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (dcount > 0) begin
                tmo = 1'b0;
                break;
            end
            if (t.abort_at >= 0 && nsent == t.abort_at) begin
                out_ready = 1'b0;
                start     = 1'b0;
                rst       = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                chk("rst_valid", 32'(out_valid), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_sel", 32'(cpuid_sel), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_last", 32'(out_last), 32'd0);
                q.delete();
                out_ready = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                chk("rst_no_done", 32'(dcount), 32'd0);
                chk("rst_idle", 32'(busy), 32'd0);
                return;
            end
            out_ready = 1'b1;
            if (nsent == t.stall_idx && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end
            @(posedge clk); #1;
        end
        if (tmo)
            chk("timeout", 32'd1, 32'd0);
        start     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("done_count", 32'(dcount), 32'd1);
        chk("word_count", 32'(nsent), 32'(WORDS));
        chk("queue_left", 32'(q.size()), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        @(posedge clk); #1;
    endtask

    vec_t tbl [5];

    initial begin
        tbl[0] = '{alt: 0, stall_idx: -1, stall_n: 0, clobber: 0,
                   spam: 0, abort_at: -1};
        tbl[1] = '{alt: 0, stall_idx: 2, stall_n: 4, clobber: 1,
                   spam: 0, abort_at: -1};
        tbl[2] = '{alt: 1, stall_idx: -1, stall_n: 0, clobber: 0,
                   spam: 1, abort_at: -1};
        tbl[3] = '{alt: 0, stall_idx: -1, stall_n: 0, clobber: 0,
                   spam: 0, abort_at: 3};
        tbl[4] = '{alt: 1, stall_idx: 4, stall_n: 2, clobber: 1,
                   spam: 1, abort_at: -1};

        for (int k = 0; k < 8; k++)
            bank[k] = '0;
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        nsent     = 0;
        dcount    = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_sel", 32'(cpuid_sel), 32'd0);
        chk("reset_data", out_data, 32'd0);
        chk("reset_index", 32'(out_index), 32'd0);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_last", 32'(out_last), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_hold", 32'(busy), 32'd0);

        for (int r = 0; r < 5; r++)
            run(tbl[r]);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
